truth_table_sweeper: RTL and testbench

- Hardware exhaustive-stimulus engine for small combinational DUTs.
- On `start` it drives every N_IN-bit input vector in binary order (0 to 2^N_IN-1) and holds each vector for a programmable settle time.
- At the end of each hold it samples the DUT output and compares it against a golden truth table latched at start.
- It reports the mismatch count, the first failing vector and pass/fail; it is the on-chip successor to hand-written exhaustive benches.

---
 rtl/truth_table_sweeper.sv | 127 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive-stimulus engine: walks every N_IN-bit input vector in binary order, holds each for
// SETTLE+1 cycles, and checks the DUT output against a golden truth table latched at start.
module truth_table_sweeper #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [(2**N_IN)-1:0]  expected,
    input  logic                  dut_y,
    output logic [N_IN-1:0]       vec_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_IN:0]         err_count,
    output logic [N_IN-1:0]       first_fail_vec,
    output logic                  first_fail_valid
);

    localparam int unsigned NumVec  = 2 ** N_IN;
    localparam logic [7:0]      HoldMax = 8'(SETTLE);
    localparam logic [N_IN-1:0] VecLast = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] VecOne  = N_IN'(1);
    localparam logic [N_IN:0]   ErrOne  = (N_IN + 1)'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [N_IN-1:0]     vec_q, vec_d;
    logic [7:0]          hold_q, hold_d;
    logic [NumVec-1:0]   exp_q, exp_d;
    logic [N_IN:0]       err_q, err_d;
    logic [N_IN-1:0]     ff_vec_q, ff_vec_d;
    logic                ff_valid_q, ff_valid_d;
    logic                mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q      <= '0;
            hold_q     <= '0;
            exp_q      <= '0;
            err_q      <= '0;
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
        end else begin
            vec_q      <= vec_d;
            hold_q     <= hold_d;
            exp_q      <= exp_d;
            err_q      <= err_d;
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
        end
    end

    assign mismatch = (dut_y != exp_q[vec_q]);

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        hold_d     = hold_q;
        exp_d      = exp_q;
        err_d      = err_q;
        ff_vec_d   = ff_vec_q;
        ff_valid_d = ff_valid_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StRun;
                    exp_d      = expected;
                    err_d      = '0;
                    ff_vec_d   = '0;
                    ff_valid_d = 1'b0;
                    vec_d      = '0;
                    hold_d     = '0;
                end
            end
            StRun: begin
                // Abort wins over a sample on the same edge; that sample is discarded.
                if (abort) begin
                    state_d = StIdle;
                    vec_d   = '0;
                    hold_d  = '0;
                end else if (hold_q != HoldMax) begin
                    hold_d = hold_q + 8'd1;
                end else begin
                    if (mismatch) begin
                        err_d = err_q + ErrOne;
                        if (!ff_valid_q) begin
                            ff_vec_d   = vec_q;
                            ff_valid_d = 1'b1;
                        end
                    end
                    hold_d = '0;
                    if (vec_q == VecLast) begin
                        state_d = StDone;
                        vec_d   = '0;
                    end else begin
                        vec_d = vec_q + VecOne;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
        pass = (state_q == StDone) && (err_q == '0);
    end

    assign vec_out          = vec_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised bench for truth_table_sweeper: three configurations share stimulus through a selector,
// and a sweep-level model derives timing and results from the truth table and fault mask.
module tb_truth_table_sweeper;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [63:0] exp_bus;
    logic [63:0] golden;
    logic [63:0] fault;
    int          sel;
    int          checks;
    int          failures;

    logic        start_a, start_b, start_c;
    logic        abort_a, abort_b, abort_c;
    logic        y_a, y_b, y_c;
    logic [3:0]  vec_a, vec_b, ff_a, ff_b;
    logic [5:0]  vec_c, ff_c;
    logic [4:0]  err_a, err_b;
    logic [6:0]  err_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic        pass_a, pass_b, pass_c, ffv_a, ffv_b, ffv_c;

    logic [5:0]  m_vec, m_ff;
    logic [6:0]  m_err;
    logic        m_busy, m_done, m_pass, m_ffv;

    int n_tab [3] = '{4, 4, 6};
    int s_tab [3] = '{1, 0, 3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);
    assign abort_a = abort && (sel == 0);
    assign abort_b = abort && (sel == 1);
    assign abort_c = abort && (sel == 2);

    // Behavioural DUTs: the golden function with selected vectors inverted.
    assign y_a = golden[vec_a] ^ fault[vec_a];
    assign y_b = golden[vec_b] ^ fault[vec_b];
    assign y_c = golden[vec_c] ^ fault[vec_c];

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .expected(exp_bus[15:0]),
        .dut_y(y_a), .vec_out(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_fail_vec(ff_a), .first_fail_valid(ffv_a)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .expected(exp_bus[15:0]),
        .dut_y(y_b), .vec_out(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_fail_vec(ff_b), .first_fail_valid(ffv_b)
    );

    truth_table_sweeper #(.N_IN(6), .SETTLE(3)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .expected(exp_bus),
        .dut_y(y_c), .vec_out(vec_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .first_fail_vec(ff_c), .first_fail_valid(ffv_c)
    );

    always_comb begin
        m_vec = '0; m_ff = '0; m_err = '0;
        m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_ffv = 1'b0;
        case (sel)
            0: begin
                m_vec = {2'b0, vec_a}; m_ff = {2'b0, ff_a}; m_err = {2'b0, err_a};
                m_busy = busy_a; m_done = done_a; m_pass = pass_a; m_ffv = ffv_a;
            end
            1: begin
                m_vec = {2'b0, vec_b}; m_ff = {2'b0, ff_b}; m_err = {2'b0, err_b};
                m_busy = busy_b; m_done = done_b; m_pass = pass_b; m_ffv = ffv_b;
            end
            default: begin
                m_vec = vec_c; m_ff = ff_c; m_err = err_c;
                m_busy = busy_c; m_done = done_c; m_pass = pass_c; m_ffv = ffv_c;
            end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full (or aborted) sweep on the selected instance, checked against the sweep model.
    task automatic sweep(input logic [63:0] gold, input logic [63:0] flt, input int abort_at,
                         input int restart_at, input int scramble_at, input string tag);
        int nv, hp, total, limit, exp_err, exp_first, bad, hold6;
        bit exp_valid, aborted;
        nv    = 1 << n_tab[sel];
        hp    = s_tab[sel] + 1;
        total = nv * hp;
        limit = (abort_at >= 0) ? abort_at / hp : nv;
        exp_err = 0; exp_valid = 0; exp_first = 0;
        for (int k = 0; k < limit; k++) begin
            if (flt[k]) begin
                exp_err++;
                if (!exp_valid) begin
                    exp_valid = 1;
                    exp_first = k;
                end
            end
        end
        golden  = gold;
        fault   = flt;
        exp_bus = gold;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        bad = 0; hold6 = 0; aborted = 0;
        for (int c = 0; c < total; c++) begin
            if (m_busy !== 1'b1 || m_done !== 1'b0 || m_vec !== 6'(c / hp)) begin
                if (bad == 0)
                    $display("FAIL %s timing cycle=%0d got vec=%0d busy=%b done=%b want vec=%0d busy=1 done=0",
                             tag, c, m_vec, m_busy, m_done, c / hp);
                bad++;
            end
            if (m_vec == 6'd6) hold6++;
            if (c == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                aborted = 1;
                break;
            end
            start = (c == restart_at);
            if (c == scramble_at) exp_bus = {$urandom, $urandom};
            tick();
        end
        start = 1'b0;
        checks++;
        if (bad != 0) failures++;
        if (aborted) begin
            checks++;
            if (m_busy !== 1'b0 || m_done !== 1'b0 || m_pass !== 1'b0 || m_vec !== 6'd0) begin
                failures++;
                $display("FAIL %s abort_state got busy=%b done=%b pass=%b vec=%0d want 0 0 0 0",
                         tag, m_busy, m_done, m_pass, m_vec);
            end
        end else begin
            checks++;
            if (m_done !== 1'b1 || m_busy !== 1'b0 || m_vec !== 6'd0) begin
                failures++;
                $display("FAIL %s done_state got done=%b busy=%b vec=%0d want done=1 busy=0 vec=0",
                         tag, m_done, m_busy, m_vec);
            end
            checks++;
            if (m_pass !== (exp_err == 0)) begin
                failures++;
                $display("FAIL %s pass got %b want %b", tag, m_pass, exp_err == 0);
            end
            checks++;
            if (hold6 != hp) begin
                failures++;
                $display("FAIL %s hold_vec6 got %0d cycles want %0d", tag, hold6, hp);
            end
        end
        checks++;
        if (m_err !== 7'(exp_err)) begin
            failures++;
            $display("FAIL %s err_count got %0d want %0d", tag, m_err, exp_err);
        end
        checks++;
        if (m_ffv !== exp_valid || m_ff !== 6'(exp_first)) begin
            failures++;
            $display("FAIL %s first_fail got valid=%b vec=%0d want valid=%b vec=%0d",
                     tag, m_ffv, m_ff, exp_valid, exp_first);
        end
        // Results must hold steady afterwards.
        tick();
        tick();
        checks++;
        if (m_done !== !aborted || m_err !== 7'(exp_err) || m_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s hold_after got done=%b err=%0d busy=%b want done=%b err=%0d busy=0",
                     tag, m_done, m_err, m_busy, !aborted, exp_err);
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (m_vec !== 0 || m_busy !== 0 || m_done !== 0 || m_pass !== 0 || m_err !== 0 ||
            m_ff !== 0 || m_ffv !== 0) begin
            failures++;
            $display("FAIL %s got vec=%0d busy=%b done=%b pass=%b err=%0d ff=%0d ffv=%b want all 0",
                     tag, m_vec, m_busy, m_done, m_pass, m_err, m_ff, m_ffv);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            check_zero("reset");
        end
        rst_n = 1'b1;
        tick();
        sel = 0;
        tick();
        check_zero("idle_after_reset");
    endtask

    task automatic test_correct_pass();
        sel = 0;
        sweep(64'hA5C3, 64'h0, -1, -1, -1, "correct_pass");
    endtask

    task automatic test_single_fault();
        sel = 0;
        sweep(64'hA5C3, (64'h1 << 6) | (64'h1 << 13), -1, -1, -1, "single_fault");
    endtask

    task automatic test_fast_inverted();
        sel = 1;
        sweep(64'hA5C3, 64'hFFFF, -1, -1, -1, "fast_inverted");
    endtask

    task automatic test_abort();
        sel = 0;
        sweep(64'hA5C3, (64'h1 << 6) | (64'h1 << 13), 18, -1, -1, "abort_v9");
        sweep(64'hA5C3, (64'h1 << 6) | (64'h1 << 13), -1, -1, -1, "after_abort");
    endtask

    task automatic test_reset_mid_run();
        sel = 0;
        golden = 64'hA5C3; fault = 64'h0; exp_bus = 64'hA5C3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_run");
        #20;
        rst_n = 1'b1;
        tick();
        tick();
        check_zero("idle_after_mid_reset");
        sweep(64'hA5C3, 64'h1 << 2, -1, 7, -1, "start_in_run");
    endtask

    task automatic test_golden_latch();
        sel = 0;
        sweep(64'h3C69, 64'h0, -1, -1, 5, "latch_n4");
        sel = 2;
        sweep({$urandom, $urandom}, 64'h0, -1, -1, 40, "latch_n6");
    endtask

    task automatic test_random();
        for (int i = 0; i < 9; i++) begin
            logic [63:0] g, f;
            int nv, total, ab;
            sel   = i % 3;
            nv    = 1 << n_tab[sel];
            total = nv * (s_tab[sel] + 1);
            g = {$urandom, $urandom};
            f = '0;
            for (int k = 0; k < nv; k++) f[k] = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, total - 1)) : -1;
            sweep(g, f, ab, int'($urandom_range(0, total - 2)), int'($urandom_range(0, total - 1)),
                  "random");
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        start = 1'b0; abort = 1'b0; sel = 0;
        exp_bus = '0; golden = '0; fault = '0;
        test_reset();
        test_correct_pass();
        test_single_fault();
        test_fast_inverted();
        test_abort();
        test_reset_mid_run();
        test_golden_latch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
